// File: rtl/sap_ctrl_seq.sv
// SAP controller-sequencer: T1..T6 ring counter plus microcode decode of the bus/load strobes.
// Optional `CTRL_EARLY_END_EN shortens machine cycles whose trailing T-states are nops.
module sap_ctrl_seq (
    input  logic       clk,
    input  logic       async_reset_n,
    input  logic       run,
    input  logic [3:0] opcode,
    output logic [5:0] t_state,
    output logic       pc_inc,
    output logic       pc_oe_n,
    output logic       mar_ie_n,
    output logic       ram_oe_n,
    output logic       ir_ie_n,
    output logic       ir_oe_n,
    output logic       a_ie_n,
    output logic       a_oe_n,
    output logic       b_ie_n,
    output logic       alu_sub,
    output logic       alu_oe_n,
    output logic       out_ie_n,
    output logic       halted
);

    typedef enum logic [2:0] {
        ST_T1   = 3'd0,
        ST_T2   = 3'd1,
        ST_T3   = 3'd2,
        ST_T4   = 3'd3,
        ST_T5   = 3'd4,
        ST_T6   = 3'd5,
        ST_HALT = 3'd6
    } state_e;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Active-high view of the control word; pins are derived from it below.
    typedef struct packed {
        logic pc_inc;
        logic pc_oe;
        logic mar_ie;
        logic ram_oe;
        logic ir_ie;
        logic ir_oe;
        logic a_ie;
        logic a_oe;
        logic b_ie;
        logic alu_sub;
        logic alu_oe;
        logic out_ie;
    } ctrl_t;

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;

`ifdef CTRL_EARLY_END_EN
    logic exec_long;
    assign exec_long = (opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_T1:   state_d = run ? ST_T2 : ST_T1;
            ST_T2:   state_d = ST_T3;
            ST_T3:   state_d = ST_T4;
            ST_T4: begin
                if (opcode == OP_HLT) begin
                    state_d = ST_HALT;
                end
`ifdef CTRL_EARLY_END_EN
                else if (!exec_long) begin
                    state_d = ST_T1;
                end
`endif
                else begin
                    state_d = ST_T5;
                end
            end
            ST_T5: begin
`ifdef CTRL_EARLY_END_EN
                state_d = (opcode == OP_LDA) ? ST_T1 : ST_T6;
`else
                state_d = ST_T6;
`endif
            end
            ST_T6:   state_d = ST_T1;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_T1;
        endcase
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state_q <= ST_T1;
        end else begin
            state_q <= state_d;
        end
    end

    // Decode is gated by reset so nothing drives the bus while reset is held.
    always_comb begin
        ctrl = '0;
        if (async_reset_n) begin
            case (state_q)
                ST_T1: begin
                    if (run) begin
                        ctrl.pc_oe  = 1'b1;
                        ctrl.mar_ie = 1'b1;
                    end
                end
                ST_T2: ctrl.pc_inc = 1'b1;
                ST_T3: begin
                    ctrl.ram_oe = 1'b1;
                    ctrl.ir_ie  = 1'b1;
                end
                ST_T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            ctrl.ir_oe  = 1'b1;
                            ctrl.mar_ie = 1'b1;
                        end
                        OP_OUT: begin
                            ctrl.a_oe   = 1'b1;
                            ctrl.out_ie = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_T5: begin
                    case (opcode)
                        OP_LDA: begin
                            ctrl.ram_oe = 1'b1;
                            ctrl.a_ie   = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ctrl.ram_oe  = 1'b1;
                            ctrl.b_ie    = 1'b1;
                            ctrl.alu_sub = (opcode == OP_SUB);
                        end
                        default: ;
                    endcase
                end
                ST_T6: begin
                    if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                        ctrl.alu_oe  = 1'b1;
                        ctrl.a_ie    = 1'b1;
                        ctrl.alu_sub = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        t_state = 6'b000000;
        case (state_q)
            ST_T1:   t_state = 6'b000001;
            ST_T2:   t_state = 6'b000010;
            ST_T3:   t_state = 6'b000100;
            ST_T4:   t_state = 6'b001000;
            ST_T5:   t_state = 6'b010000;
            ST_T6:   t_state = 6'b100000;
            default: t_state = 6'b000000;
        endcase
    end

    assign halted   = (state_q == ST_HALT);
    assign pc_inc   = ctrl.pc_inc;
    assign pc_oe_n  = ~ctrl.pc_oe;
    assign mar_ie_n = ~ctrl.mar_ie;
    assign ram_oe_n = ~ctrl.ram_oe;
    assign ir_ie_n  = ~ctrl.ir_ie;
    assign ir_oe_n  = ~ctrl.ir_oe;
    assign a_ie_n   = ~ctrl.a_ie;
    assign a_oe_n   = ~ctrl.a_oe;
    assign b_ie_n   = ~ctrl.b_ie;
    assign alu_sub  = ctrl.alu_sub;
    assign alu_oe_n = ~ctrl.alu_oe;
    assign out_ie_n = ~ctrl.out_ie;

endmodule

// File: tb/tb_sap_ctrl_seq.sv
// Testbench for sap_ctrl_seq: per-instruction expected control-word queues built from the
// instruction table, randomized opcode/run noise, reset and halt scenarios.
module tb_sap_ctrl_seq;

    logic       clk = 1'b0;
    logic       async_reset_n;
    logic       run;
    logic [3:0] opcode;
    logic [5:0] t_state;
    logic       pc_inc, pc_oe_n, mar_ie_n, ram_oe_n, ir_ie_n, ir_oe_n;
    logic       a_ie_n, a_oe_n, b_ie_n, alu_sub, alu_oe_n, out_ie_n, halted;

    int n_vec = 0;
    int n_err = 0;

`ifdef CTRL_EARLY_END_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    localparam logic [11:0] M_PC_INC  = 12'h001;
    localparam logic [11:0] M_PC_OE   = 12'h002;
    localparam logic [11:0] M_MAR_IE  = 12'h004;
    localparam logic [11:0] M_RAM_OE  = 12'h008;
    localparam logic [11:0] M_IR_IE   = 12'h010;
    localparam logic [11:0] M_IR_OE   = 12'h020;
    localparam logic [11:0] M_A_IE    = 12'h040;
    localparam logic [11:0] M_A_OE    = 12'h080;
    localparam logic [11:0] M_B_IE    = 12'h100;
    localparam logic [11:0] M_ALU_SUB = 12'h200;
    localparam logic [11:0] M_ALU_OE  = 12'h400;
    localparam logic [11:0] M_OUT_IE  = 12'h800;
    localparam logic [11:0] M_BUS     = M_PC_OE | M_RAM_OE | M_IR_OE | M_A_OE | M_ALU_OE;

    always #5 clk = ~clk;

    sap_ctrl_seq dut (
        .clk           (clk),
        .async_reset_n (async_reset_n),
        .run           (run),
        .opcode        (opcode),
        .t_state       (t_state),
        .pc_inc        (pc_inc),
        .pc_oe_n       (pc_oe_n),
        .mar_ie_n      (mar_ie_n),
        .ram_oe_n      (ram_oe_n),
        .ir_ie_n       (ir_ie_n),
        .ir_oe_n       (ir_oe_n),
        .a_ie_n        (a_ie_n),
        .a_oe_n        (a_oe_n),
        .b_ie_n        (b_ie_n),
        .alu_sub       (alu_sub),
        .alu_oe_n      (alu_oe_n),
        .out_ie_n      (out_ie_n),
        .halted        (halted)
    );

    // Which controls are asserted right now, in active-high form.
    function automatic logic [11:0] act_vec();
        return {~out_ie_n, ~alu_oe_n, alu_sub, ~b_ie_n, ~a_oe_n, ~a_ie_n,
                ~ir_oe_n, ~ir_ie_n, ~ram_oe_n, ~mar_ie_n, ~pc_oe_n, pc_inc};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a posedge; samples mid-cycle, then advances one clock.
    task automatic cycle(input string tag, input logic [5:0] exp_t,
                         input logic [11:0] exp_m, input logic exp_h);
        #3;
        chk({tag, "/t_state"}, 32'(t_state), 32'(exp_t));
        chk({tag, "/ctrl"}, 32'(act_vec()), 32'(exp_m));
        chk({tag, "/halted"}, 32'(halted), 32'(exp_h));
        chk({tag, "/bus1hot"}, 32'($countones(act_vec() & M_BUS) <= 1), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction (or its first n_states T-states if n_states > 0).
    task automatic exec_instr(input logic [3:0] op, input bit drop_run, input int n_states);
        logic [11:0] q[$];
        int          n;
        q = {M_PC_OE | M_MAR_IE, M_PC_INC, M_RAM_OE | M_IR_IE};
        case (op)
            4'h0: begin
                q.push_back(M_IR_OE | M_MAR_IE);
                q.push_back(M_RAM_OE | M_A_IE);
                if (!EARLY) q.push_back(12'h000);
            end
            4'h1: begin
                q.push_back(M_IR_OE | M_MAR_IE);
                q.push_back(M_RAM_OE | M_B_IE);
                q.push_back(M_ALU_OE | M_A_IE);
            end
            4'h2: begin
                q.push_back(M_IR_OE | M_MAR_IE);
                q.push_back(M_RAM_OE | M_B_IE | M_ALU_SUB);
                q.push_back(M_ALU_OE | M_A_IE | M_ALU_SUB);
            end
            4'hE: begin
                q.push_back(M_A_OE | M_OUT_IE);
                if (!EARLY) begin
                    q.push_back(12'h000);
                    q.push_back(12'h000);
                end
            end
            4'hF: q.push_back(12'h000);
            default: begin
                q.push_back(12'h000);
                if (!EARLY) begin
                    q.push_back(12'h000);
                    q.push_back(12'h000);
                end
            end
        endcase
        n = (n_states > 0) ? n_states : q.size();
        for (int k = 0; k < n; k++) begin
            if (k == 0)                  run = 1'b1;
            else if (drop_run && k >= 2) run = 1'b0;
            else                         run = 1'($urandom);
            opcode = (k < 3) ? 4'($urandom) : op;
            cycle($sformatf("op%h_T%0d", op, k + 1), 6'(1 << k), q[k], 1'b0);
        end
    endtask

    initial begin
        async_reset_n = 1'b0;
        run           = 1'b1;
        opcode        = 4'h0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            opcode = 4'($urandom);
            cycle("reset_hold", 6'b000001, 12'h000, 1'b0);
        end
        async_reset_n = 1'b1;

        exec_instr(4'h1, 1'b0, 0);
        exec_instr(4'h2, 1'b0, 0);
        exec_instr(4'h0, 1'b0, 0);
        exec_instr(4'hE, 1'b0, 0);
        exec_instr(4'h7, 1'b0, 0);

        run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            opcode = 4'($urandom);
            cycle("stall", 6'b000001, 12'h000, 1'b0);
        end
        exec_instr(4'h1, 1'b1, 0);
        for (int i = 0; i < 3; i++) begin
            cycle("stall_after_drop", 6'b000001, 12'h000, 1'b0);
        end

        for (int i = 0; i < 40; i++) begin
            exec_instr(4'($urandom_range(0, 14)), 1'b0, 0);
        end

        exec_instr(4'h0, 1'b0, 4);
        async_reset_n = 1'b0;
        run           = 1'b1;
        cycle("lda_rst", 6'b000001, 12'h000, 1'b0);
        cycle("lda_rst", 6'b000001, 12'h000, 1'b0);
        async_reset_n = 1'b1;
        exec_instr(4'h0, 1'b0, 0);

        exec_instr(4'hF, 1'b0, 0);
        for (int i = 0; i < 20; i++) begin
            run    = 1'b1;
            opcode = 4'($urandom);
            cycle("halt", 6'b000000, 12'h000, 1'b1);
        end
        async_reset_n = 1'b0;
        cycle("halt_rst", 6'b000001, 12'h000, 1'b0);
        async_reset_n = 1'b1;
        exec_instr(4'h2, 1'b0, 0);
        exec_instr(4'hE, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sap_ctrl_seq.md
# sap_ctrl_seq

Controller-sequencer for the SAP datapath: a six-state T-state ring counter plus a microcode decoder that drives the active-low load (`i_en`) and output (`o_en`) pins of the 8-bit tristate registers. It also drives the PC, RAM and ALU strobes. It takes the opcode nibble from the instruction register and sequences fetch and execute so that at most one source drives the shared bus in any T-state.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on posedge.
- `async_reset_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  sampled in T1 only; 0 holds the sequencer idle in T1.
- `opcode`  in  4  instruction register upper nibble; valid from T4 to T6.
- `t_state`  out  6  one-hot ring counter; bit0 = T1.
- `pc_inc`  out  1  PC count enable, active high.
- `pc_oe_n`  out  1  PC bus drive, active low.
- `mar_ie_n`  out  1  MAR load, active low.
- `ram_oe_n`  out  1  RAM bus drive, active low.
- `ir_ie_n` / `ir_oe_n`  out  1 each  IR load / IR operand-nibble bus drive, active low.
- `a_ie_n` / `a_oe_n`  out  1 each  accumulator load / drive, active low.
- `b_ie_n`  out  1  B register load, active low.
- `alu_sub`  out  1  ALU subtract select, active high.
- `alu_oe_n`  out  1  ALU result bus drive, active low.
- `out_ie_n`  out  1  output register load, active low.
- `halted`  out  1  high in HALT state.

## Operation
- States: T1..T6 (one-hot) and HALT. Control outputs are a combinational decode of state and `opcode`. Unlisted outputs are inactive (`_n` = 1, active-high = 0).
- T1: `pc_oe_n`=0, `mar_ie_n`=0. If `run`=0: stay in T1 and force all controls inactive. Otherwise go to T2.
- T2: `pc_inc`=1.
- T3: `ram_oe_n`=0, `ir_ie_n`=0. The IR loads at the end of T3; `opcode` is used from T4.
- LDA (0000): T4 `ir_oe_n`, `mar_ie_n`. T5 `ram_oe_n`, `a_ie_n`. T6 nop.
- ADD (0001): T4 `ir_oe_n`, `mar_ie_n`. T5 `ram_oe_n`, `b_ie_n`. T6 `alu_oe_n`, `a_ie_n`.
- SUB (0010): same as ADD, plus `alu_sub`=1 in T5 and T6.
- OUT (1110): T4 `a_oe_n`, `out_ie_n`. T5 and T6 nop.
- HLT (1111): T4 asserts nothing. At the T4 posedge, go to HALT.
- HALT: all controls inactive, `t_state`=0, `halted`=1. Only reset exits HALT.
- Every other opcode: nop in T4-T6.
- T6 always goes to T1.
- Invariant: at most one of `pc_oe_n`, `ram_oe_n`, `ir_oe_n`, `a_oe_n`, `alu_oe_n` is low in any cycle.

## Timing
- Reset asserted:
  - State goes to T1 immediately; `t_state`=6'b000001.
  - `halted`=0.
  - All controls forced inactive, including T1 controls, for as long as reset is held.
- Reset mid-instruction or in HALT: aborts at once. After release, T1 outputs appear in the same cycle, gated by `run`.
- Datapath registers sample on the posedge that ends each T-state, so the control word must be stable for the whole state.
- One T-state per clock. A full instruction takes 6 clocks; HLT takes 4 clocks to reach HALT.
- `run` dropping mid-instruction has no effect. The instruction completes and the sequencer stalls at the next T1.

## Configuration
- `CTRL_EARLY_END_EN` defined: the machine cycle is shortened where trailing states are nop.
  - LDA: T5 -> T1.
  - OUT: T4 -> T1.
  - Unlisted opcodes: T4 -> T1.
  - ADD/SUB still use 6 states; HLT is unchanged.
- Not defined: every instruction passes through all of T1-T6 (except HLT).

## Test plan
- Reset held with `run`=1 -> `t_state`=000001, all `_n` outputs 1, `pc_inc`=0. After release, cycle 1 has `pc_oe_n`=`mar_ie_n`=0.
- `run`=1, opcode 0001 -> cycle order T1..T6. T5 has `ram_oe_n`=`b_ie_n`=0. T6 has `alu_oe_n`=`a_ie_n`=0 and `alu_sub`=0. Back at T1 on the 7th clock.
- Opcode 0010 -> identical to ADD except `alu_sub`=1 in T5 and T6. Bus-drive one-hot check passes every cycle.
- Opcode 1111 -> HALT after T4, `halted`=1. Then 20 clocks with `run`=1 -> all outputs inactive. A reset pulse then returns to T1 with `halted`=0.
- `run`=0 at T1 -> 10 clocks with `t_state`=000001 and no controls. Raise `run` -> T2 on the next clock. Lower `run` at T3 -> instruction completes, then stall.
- Opcode 1110 -> with the macro, T4 (`a_oe_n`=`out_ie_n`=0) then T1. Without the macro, T5 and T6 nop, then T1. Also assert reset during T5 of LDA -> `a_ie_n` never pulses and the sequencer restarts at T1.
